// File: rtl/apb_fifo_slave.sv
// APB slave exposing a byte FIFO through FSR/FWD/FRD/IER registers, one wait state per access.
// Optional: define APB_FIFO_IRQ_EN to add the IER register and the irq output.
module apb_fifo_slave #(
    parameter int DEPTH = 8,
    parameter int DW    = 8
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [3:0]  PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        PREADY
`ifdef APB_FIFO_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, ACK} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          ovf, unf;
    logic          empty, full;
    logic          access;
    logic          wr_fsr, wr_fwd, rd_frd, push_ok;
    logic [7:0]    cnt8;
    logic [31:0]   rdata_nxt;
    logic          unused_bits;
`ifdef APB_FIFO_IRQ_EN
    logic [1:0]    ier;
    logic          wr_ier;
`endif

    assign empty       = (count == '0);
    assign full        = (count == (AW+1)'(DEPTH));
    assign cnt8        = 8'(count);
    assign unused_bits = ^{PADDR[1:0], PWDATA};

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state <= IDLE;
        else        state <= state_nxt;
    end

    // access is the single-cycle strobe for all side effects; ACK never re-arms it
    always_comb begin
        state_nxt = state;
        access    = 1'b0;
        case (state)
            IDLE: if (PSEL && PENABLE) begin
                state_nxt = ACK;
                access    = 1'b1;
            end
            ACK:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign wr_fsr  = access &  PWRITE & (PADDR[3:2] == 2'd0);
    assign wr_fwd  = access &  PWRITE & (PADDR[3:2] == 2'd1);
    assign rd_frd  = access & ~PWRITE & (PADDR[3:2] == 2'd2);
    assign push_ok = wr_fwd & ~full;
`ifdef APB_FIFO_IRQ_EN
    assign wr_ier  = access &  PWRITE & (PADDR[3:2] == 2'd3);
`endif

    always_comb begin
        rdata_nxt = '0;
        if (!PWRITE) begin
            case (PADDR[3:2])
                2'd0: rdata_nxt = {16'h0000, cnt8, 4'h0, unf, ovf, full, empty};
                2'd2: if (!empty) rdata_nxt = 32'(mem[rd_ptr]);
`ifdef APB_FIFO_IRQ_EN
                2'd3: rdata_nxt = {30'd0, ier};
`endif
                default: rdata_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (push_ok && !PRESET) mem[wr_ptr] <= PWDATA[DW-1:0];
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PREADY <= 1'b0;
            PRDATA <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            PREADY <= access;
            if (access) PRDATA <= rdata_nxt;
            if (wr_fsr && PWDATA[4]) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                ovf    <= 1'b0;
                unf    <= 1'b0;
            end else if (wr_fwd) begin
                if (full) begin
                    ovf <= 1'b1;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                    count  <= count + 1'b1;
                end
            end else if (rd_frd) begin
                if (empty) begin
                    unf <= 1'b1;
                end else begin
                    rd_ptr <= rd_ptr + 1'b1;
                    count  <= count - 1'b1;
                end
            end
        end
    end

`ifdef APB_FIFO_IRQ_EN
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ier <= '0;
            irq <= 1'b0;
        end else begin
            if (wr_ier) ier <= PWDATA[1:0];
            irq <= (ier[0] & ~empty) | (ier[1] & full);
        end
    end
`endif

endmodule

// File: tb/tb_apb_fifo_slave.sv
// Directed bench for apb_fifo_slave (DEPTH=8, DW=8); covers irq when APB_FIFO_IRQ_EN is defined.
module tb_apb_fifo_slave;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PENABLE;
    logic        PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;
`ifdef APB_FIFO_IRQ_EN
    logic        irq;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned last_lat;
    logic        last_rdy_after;
    logic        irq_ack;
    logic [31:0] rd;

    apb_fifo_slave #(.DEPTH(8), .DW(8)) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PWRITE  (PWRITE),
        .PENABLE (PENABLE),
        .PSEL    (PSEL),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY)
`ifdef APB_FIFO_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    always #5 PCLK = ~PCLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One full APB transfer; samples 1 time unit after each rising edge.
    task automatic apb_xfer(input logic [3:0] a, input logic w, input logic [31:0] wd,
                            output logic [31:0] rdv);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = w; PWDATA = wd;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        last_lat = 1;
        while (!PREADY && last_lat < 8) begin
            @(posedge PCLK); #1;
            last_lat++;
        end
        if (!PREADY) check_val("pready_timeout", {31'd0, PREADY}, 32'd1);
        rdv = PRDATA;
`ifdef APB_FIFO_IRQ_EN
        irq_ack = irq;
`else
        irq_ack = 1'b0;
`endif
        @(posedge PCLK); #1;
        last_rdy_after = PREADY;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;
        irq_ack = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        check_val("reset_pready", {31'd0, PREADY}, 32'd0);
        check_val("reset_prdata", PRDATA, 32'd0);
        PRESET = 1'b0;

        // reset state and wait-state timing
        apb_xfer(4'h0, 1'b0, '0, rd);
        check_val("fsr_after_reset", rd, 32'h0000_0001);
        check_val("ready_latency", last_lat, 32'd1);
        check_val("ready_one_cycle", {31'd0, last_rdy_after}, 32'd0);
        check_val("prdata_hold", PRDATA, 32'h0000_0001);

        // basic push/pop ordering
        apb_xfer(4'h4, 1'b1, 32'h0000_00A5, rd);
        check_val("write_prdata_zero", rd, 32'd0);
        apb_xfer(4'h0, 1'b0, '0, rd);
        check_val("fsr_count1", rd, 32'h0000_0100);
        apb_xfer(4'h4, 1'b1, 32'hFFFF_FF3C, rd);
        apb_xfer(4'h4, 1'b1, 32'h0000_007E, rd);
        apb_xfer(4'h8, 1'b1, 32'h0000_0011, rd);
        apb_xfer(4'h4, 1'b0, '0, rd);
        check_val("fwd_read_zero", rd, 32'd0);
        apb_xfer(4'h0, 1'b0, '0, rd);
        check_val("fsr_count3", rd, 32'h0000_0300);
        apb_xfer(4'h8, 1'b0, '0, rd);
        check_val("pop0", rd, 32'h0000_00A5);
        apb_xfer(4'h8, 1'b0, '0, rd);
        check_val("pop1", rd, 32'h0000_003C);
        apb_xfer(4'h8, 1'b0, '0, rd);
        check_val("pop2", rd, 32'h0000_007E);
        apb_xfer(4'h0, 1'b0, '0, rd);
        check_val("fsr_empty_again", rd, 32'h0000_0001);

        // fill, overflow, drain; pointers start at 3, so the first pass wraps
        for (int unsigned rep = 0; rep < 2; rep++) begin
            for (int unsigned i = 0; i < 8; i++) apb_xfer(4'h4, 1'b1, 32'(i), rd);
            apb_xfer(4'h4, 1'b1, 32'h0000_00FF, rd);
            apb_xfer(4'h0, 1'b0, '0, rd);
            check_val("fsr_full_ovf", rd, 32'h0000_0806);
            for (int unsigned i = 0; i < 8; i++) begin
                apb_xfer(4'h8, 1'b0, '0, rd);
                check_val("drain", rd, 32'(i));
            end
            apb_xfer(4'h0, 1'b0, '0, rd);
            check_val("fsr_drained_ovf", rd, 32'h0000_0005);
            apb_xfer(4'h0, 1'b1, 32'h0000_0010, rd);
        end

        // underflow and flush
        apb_xfer(4'h8, 1'b0, '0, rd);
        check_val("pop_empty", rd, 32'd0);
        apb_xfer(4'h0, 1'b0, '0, rd);
        check_val("fsr_underflow", rd, 32'h0000_0009);
        apb_xfer(4'h0, 1'b1, 32'h0000_000F, rd);
        apb_xfer(4'h0, 1'b0, '0, rd);
        check_val("fsr_no_flush_bit", rd, 32'h0000_0009);
        apb_xfer(4'h0, 1'b1, 32'h0000_0010, rd);
        apb_xfer(4'h0, 1'b0, '0, rd);
        check_val("fsr_flushed", rd, 32'h0000_0001);

`ifdef APB_FIFO_IRQ_EN
        apb_xfer(4'hC, 1'b1, 32'h0000_0001, rd);
        apb_xfer(4'hC, 1'b0, '0, rd);
        check_val("ier_readback", rd, 32'h0000_0001);
        check_val("irq_idle", {31'd0, irq}, 32'd0);
        apb_xfer(4'h4, 1'b1, 32'h0000_0055, rd);
        check_val("irq_at_push_ack", {31'd0, irq_ack}, 32'd0);
        check_val("irq_after_push", {31'd0, irq}, 32'd1);
        apb_xfer(4'h8, 1'b0, '0, rd);
        check_val("irq_pop_data", rd, 32'h0000_0055);
        check_val("irq_at_pop_ack", {31'd0, irq_ack}, 32'd1);
        check_val("irq_after_pop", {31'd0, irq}, 32'd0);
`else
        apb_xfer(4'hC, 1'b1, 32'h0000_0003, rd);
        apb_xfer(4'hC, 1'b0, '0, rd);
        check_val("ier_absent", rd, 32'd0);
`endif

        // reset during the ACK cycle of a push
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 4'h4; PWRITE = 1'b1; PWDATA = 32'h0000_0042;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        check_val("ack_before_reset", {31'd0, PREADY}, 32'd1);
        PRESET = 1'b1;
        #1;
        check_val("ready_async_drop", {31'd0, PREADY}, 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        apb_xfer(4'h0, 1'b0, '0, rd);
        check_val("fsr_after_abort", rd, 32'h0000_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/apb_fifo_slave.md
# apb_fifo_slave

APB responder peripheral that exposes a parameterised byte FIFO through four 32-bit registers. It sits behind one PSELx/PRDATAx/PREADYx slot of the system APB master, occupying a 4 KB window of which only PADDR[3:0] is decoded. Every access is acknowledged with exactly one wait state via a registered PREADY. The CPU pushes and pops data through the FWD and FRD registers, polls status in FSR and, when compiled in, receives a level interrupt.

## Interface
- DEPTH, 8, FIFO entries; power of two, 2..128
- DW, 8, FIFO data width; 1..32; pushed data is PWDATA[DW-1:0], popped data is zero-extended to 32 bits

- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  reset; asynchronous, active-high
- PADDR  in  4  register offset; PADDR[1:0] ignored
- PWDATA  in  32  write data
- PWRITE  in  1  1 = write, 0 = read
- PENABLE  in  1  APB access phase
- PSEL  in  1  slave select from master decoder
- PRDATA  out  32  read data, registered
- PREADY  out  1  transfer complete, registered
- irq  out  1  level interrupt, registered; present only with APB_FIFO_IRQ_EN

## Operation
- Register map:
  - 0x0 FSR: read bit0 empty, bit1 full, bit2 overflow (sticky), bit3 underflow (sticky), bits[15:8] count, others 0.
  - 0x0 FSR write: bit4 = 1 flushes the FIFO: pointers and count to 0, both sticky bits cleared. Other bits are ignored.
  - 0x4 FWD: write pushes PWDATA[DW-1:0]. Reads return 0.
  - 0x8 FRD: read pops the head entry and returns it. Writes are ignored.
  - 0xC IER: bit0 not-empty enable, bit1 full enable; R/W. Present only with the macro.
- Handshake FSM, two states:
  - IDLE: if PSEL & PENABLE, go to ACK. At that edge PREADY<=1, PRDATA is loaded, and the register side effect (push/pop/flush/IER write) executes.
  - ACK: PREADY<=0, go to IDLE unconditionally.
- Each access therefore takes one cycle in the setup phase plus two cycles in the access phase. Side effects occur exactly once per transfer.
- Push when full: data is dropped, pointers are unchanged, overflow is set.
- Pop when empty: PRDATA = 0, pointers are unchanged, underflow is set.
- PRDATA for writes: loaded with 0.
- PRDATA between transfers: holds its last value.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Push and pop are never simultaneous, because there is a single APB port.
- PSEL or PENABLE deasserted in ACK (protocol violation): the FSM still returns to IDLE and no second side effect occurs.

## Timing
- Reset values: PREADY=0, PRDATA=0, irq=0, FSM=IDLE, count=0, pointers=0, sticky bits=0, IER=0. FIFO storage contents are don't-care.
- Reset asserted mid-transfer aborts it immediately: PREADY drops asynchronously and no side effect is committed.
- Latency:
  - PREADY rises on the first edge after PSEL&PENABLE is sampled high, and stays high for exactly one cycle.
  - A pushed value is readable on the next transfer.
  - FSR reflects the push or pop starting on the cycle after the ACK edge.
- irq updates one cycle after the status changes.

## Configuration
- APB_FIFO_IRQ_EN defined:
  - IER register and irq port exist.
  - irq <= (IER[0] & !empty) | (IER[1] & full).
- APB_FIFO_IRQ_EN undefined:
  - No irq port.
  - Offset 0xC reads 0 and writes to it are ignored.

## Test plan
- Reset, then read FSR: PRDATA=0x0000_0001 (empty), and PREADY high exactly one cycle, on the second access-phase cycle.
- Write 0xA5, 0x3C, 0x7E to 0x4, then read 0x8 three times: returns 0xA5, 0x3C, 0x7E. FSR then reads 0x0000_0001.
- Fill with DEPTH=8 pushes of 0..7, plus a 9th push of 0xFF: FSR=0x0000_0806 (count 8, full, overflow). Next 8 pops return 0..7 and 0xFF never appears. Repeat the whole sequence twice to exercise pointer wrap.
- Pop when empty: PRDATA=0 and FSR bit3=1. Then write 0x10 to FSR: FSR=0x0000_0001.
- With APB_FIFO_IRQ_EN: write IER=0x1, then push 0x55. irq rises 1 cycle after the ACK edge and falls 1 cycle after the pop empties the FIFO.
- Assert PRESET during the ACK cycle of a push: PREADY drops immediately, and FSR read after reset = 0x0000_0001.
